// File: rtl/instr_feeder_pkg.sv
// instr_feeder_pkg
//   Shared types and constants for the serial instruction feeder.
//   WORD_W       : width of one CPU instruction word {opcode, selA, selB}
//   issueState_t : encoding of the issue FSM (IDLE, ISSUE, GAP)
//   word_t       : one instruction word
package instr_feeder_pkg;

  localparam int WORD_W    = 6;
  localparam int BIT_CNT_W = 3;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } issueState_t;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int cntWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_feeder_if.sv
// instr_feeder_if
//   Bundles the serial input, issue control and CPU-facing outputs of
//   instr_feeder.
//   ser_data/ser_valid : serial instruction bits, MSB first
//   run                : issue enable
//   instr/instr_valid  : issued word and one-cycle step strobe
//   fifo_count/full/empty/overflow : queue status
//   Modports: slave (the feeder itself), master (whoever drives it).
interface instr_feeder_if import instr_feeder_pkg::*; #(
  parameter int DEPTH = 4
) ();

  logic                   ser_data;
  logic                   ser_valid;
  logic                   run;
  word_t                  instr;
  logic                   instr_valid;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   full;
  logic                   empty;
  logic                   overflow;

  modport slave (
    input  ser_data, ser_valid, run,
    output instr, instr_valid, fifo_count, full, empty, overflow
  );

  modport master (
    output ser_data, ser_valid, run,
    input  instr, instr_valid, fifo_count, full, empty, overflow
  );

endinterface

// File: rtl/instr_feeder_fifo.sv
// instr_fifo
//   Instruction word queue, DEPTH entries (power of two, >= 2).
//   clk, rst  : clock, asynchronous active-high reset
//   push      : write pushData (accepted when not full, or when popping)
//   pop       : drop the head word (ignored when empty)
//   popData   : current head word (combinational read)
//   count     : words held, 0..DEPTH
//   full/empty: occupancy flags
module instr_fifo import instr_feeder_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  word_t                  pushData,
  input  logic                   pop,
  output word_t                  popData,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cntWidth(DEPTH);

  word_t         mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          pushOk;
  logic          popOk;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign popOk   = pop && !empty;
  // A simultaneous pop frees the slot the push lands in, so a full queue
  // can still accept the word.
  assign pushOk  = push && (!full || popOk);
  assign popData = mem[rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + AW'(1);
      if (popOk)  rdPtr <= rdPtr + AW'(1);
      case ({pushOk, popOk})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage is not reset; only words behind valid pointers are ever read.
  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/instr_feeder.sv
// instr_feeder
//   Deserializes a 1-bit instruction stream into 6-bit words, queues them
//   and issues one word every third cycle at most while run is high.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : instr_feeder_if.slave (serial input, run, instr/instr_valid,
//              fifo_count/full/empty/overflow)
module instr_feeder import instr_feeder_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  instr_feeder_if.slave      bus
);

  logic [WORD_W-1:0]    shiftReg;
  logic [BIT_CNT_W-1:0] bitCnt;
  logic                 wordDone;
  word_t                newWord;
  word_t                headWord;
  issueState_t          state;
  issueState_t          stateNxt;
  logic                 pop;
  logic                 overflowFlag;

  // ---- deserializer ----
  assign wordDone = bus.ser_valid && (bitCnt == BIT_CNT_W'(WORD_W - 1));
  // The completing bit is taken straight from the input so the word is
  // pushed on the same edge that samples it.
  assign newWord  = {shiftReg[WORD_W-2:0], bus.ser_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shiftReg <= '0;
      bitCnt   <= '0;
    end else if (bus.ser_valid) begin
      shiftReg <= newWord;
      bitCnt   <= wordDone ? '0 : bitCnt + BIT_CNT_W'(1);
    end
  end

  // ---- queue ----
  instr_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wordDone),
    .pushData (newWord),
    .pop      (pop),
    .popData  (headWord),
    .count    (bus.fifo_count),
    .full     (bus.full),
    .empty    (bus.empty)
  );

  // A word is lost only when the queue is full and nothing leaves on the
  // same edge; the flag then holds until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflowFlag <= 1'b0;
    end else if (wordDone && bus.full && !pop) begin
      overflowFlag <= 1'b1;
    end
  end

  assign bus.overflow = overflowFlag;

  // ---- issue FSM ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  // Once ISSUE is entered the ISSUE->GAP->IDLE walk always completes, so
  // the CPU always sees a quiet cycle after each step regardless of run.
  always_comb begin
    stateNxt        = state;
    pop             = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    case (state)
      IDLE: begin
        if (bus.run && !bus.empty) stateNxt = ISSUE;
      end
      ISSUE: begin
        stateNxt        = GAP;
        pop             = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr       = headWord;
      end
      GAP: begin
        stateNxt = IDLE;
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_feeder.sv
// tb_instr_feeder
//   Directed-vector bench for instr_feeder (DEPTH = 4). Inputs change and
//   outputs are sampled on the falling clock edge.
module tb_instr_feeder;
  import instr_feeder_pkg::*;

  logic clk;
  logic rst;
  int   nTests;
  int   nFail;
  int   cyc;

  instr_feeder_if #(.DEPTH(4)) bus ();

  instr_feeder #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive bits w[hi] down to w[lo], one per cycle, leaving ser_valid high.
  task automatic shiftBits(input logic [5:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      @(negedge clk);
      bus.ser_data  = w[i];
      bus.ser_valid = 1'b1;
    end
  endtask

  // Full word; returns on the falling edge just after the pushing edge.
  task automatic sendWord(input logic [5:0] w);
    shiftBits(w, 5, 0);
    @(negedge clk);
    bus.ser_valid = 1'b0;
    bus.ser_data  = 1'b0;
  endtask

  // Wait (bounded) for the next issue strobe and check the issued word.
  task automatic waitIssue(input string tag, input logic [5:0] exp,
                           input int budget, output int cycAt);
    logic found;
    found = 1'b0;
    cycAt = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.instr_valid) begin
        found = 1'b1;
        cycAt = cyc;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(found), 32'd1);
    if (found) chk(tag, 32'(bus.instr), 32'(exp));
  endtask

  // Count issue strobes over n cycles.
  task automatic countIssues(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.instr_valid) seen++;
    end
  endtask

  logic [5:0] t6Words [8];
  int         c [4];
  int         seen;
  int         dummy;

  initial begin
    nTests        = 0;
    nFail         = 0;
    bus.ser_data  = 1'b0;
    bus.ser_valid = 1'b0;
    bus.run       = 1'b0;
    rst           = 1'b1;
    t6Words = '{6'h15, 6'h2A, 6'h33, 6'h0C, 6'h3F, 6'h00, 6'h21, 6'h1E};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_count",    32'(bus.fifo_count),  32'd0);
    chk("rst_empty",    32'(bus.empty),       32'd1);
    chk("rst_full",     32'(bus.full),        32'd0);
    chk("rst_overflow", 32'(bus.overflow),    32'd0);
    chk("rst_valid",    32'(bus.instr_valid), 32'd0);
    chk("rst_instr",    32'(bus.instr),       32'd0);
    rst = 1'b0;

    // Single word, run high from IDLE: count 1, then one strobe, then empty
    bus.run = 1'b1;
    sendWord(6'b101101);
    chk("t1_count_after_push", 32'(bus.fifo_count),  32'd1);
    chk("t1_not_yet_valid",    32'(bus.instr_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid",            32'(bus.instr_valid), 32'd1);
    chk("t1_instr",            32'(bus.instr),       32'h2D);
    @(negedge clk);
    chk("t1_valid_drop",       32'(bus.instr_valid), 32'd0);
    chk("t1_instr_zero",       32'(bus.instr),       32'd0);
    chk("t1_count_zero",       32'(bus.fifo_count),  32'd0);

    // Fill with run low, overflow on 5th, then drain in order 3 cycles apart
    bus.run = 1'b0;
    sendWord(6'h01);
    sendWord(6'h02);
    sendWord(6'h03);
    sendWord(6'h04);
    chk("t2_full",           32'(bus.full),       32'd1);
    chk("t2_count4",         32'(bus.fifo_count), 32'd4);
    chk("t2_no_ovf_yet",     32'(bus.overflow),   32'd0);
    sendWord(6'h3F);
    chk("t2_overflow",       32'(bus.overflow),   32'd1);
    chk("t2_count_still4",   32'(bus.fifo_count), 32'd4);
    bus.run = 1'b1;
    waitIssue("t2_w0", 6'h01, 6, c[0]);
    waitIssue("t2_w1", 6'h02, 6, c[1]);
    waitIssue("t2_w2", 6'h03, 6, c[2]);
    waitIssue("t2_w3", 6'h04, 6, c[3]);
    chk("t2_space01", 32'(c[1] - c[0]), 32'd3);
    chk("t2_space12", 32'(c[2] - c[1]), 32'd3);
    chk("t2_space23", 32'(c[3] - c[2]), 32'd3);
    @(negedge clk);
    chk("t2_drained",        32'(bus.fifo_count), 32'd0);
    chk("t2_empty",          32'(bus.empty),      32'd1);
    chk("t2_ovf_sticky",     32'(bus.overflow),   32'd1);
    bus.run = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t2_async_rst_ovf",  32'(bus.overflow),   32'd0);
    chk("t2_async_rst_empty",32'(bus.empty),      32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Full queue: complete a word on the popping edge
    sendWord(6'h05);
    sendWord(6'h06);
    sendWord(6'h07);
    sendWord(6'h08);
    shiftBits(6'h2A, 5, 1);
    @(negedge clk);
    bus.ser_valid = 1'b0;
    bus.run       = 1'b1;
    @(negedge clk);
    chk("t3_issue_valid",    32'(bus.instr_valid), 32'd1);
    chk("t3_issue_head",     32'(bus.instr),       32'h05);
    bus.ser_data  = 1'b0;
    bus.ser_valid = 1'b1;
    @(negedge clk);
    bus.ser_valid = 1'b0;
    bus.run       = 1'b0;
    chk("t3_count_stays4",   32'(bus.fifo_count),  32'd4);
    chk("t3_no_overflow",    32'(bus.overflow),    32'd0);
    chk("t3_full",           32'(bus.full),        32'd1);
    bus.run = 1'b1;
    waitIssue("t3_w1", 6'h06, 8, dummy);
    waitIssue("t3_w2", 6'h07, 6, dummy);
    waitIssue("t3_w3", 6'h08, 6, dummy);
    waitIssue("t3_w4", 6'h2A, 6, dummy);

    // Reset mid-word discards the partial bits
    shiftBits(6'b111000, 5, 3);
    @(negedge clk);
    bus.ser_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t4_rst_count",      32'(bus.fifo_count),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    sendWord(6'b110011);
    waitIssue("t4_word", 6'h33, 6, dummy);
    countIssues(8, seen);
    chk("t4_single_issue",   32'(seen),            32'd0);
    chk("t4_count_zero",     32'(bus.fifo_count),  32'd0);

    // Drop run during GAP with two words queued
    bus.run = 1'b0;
    sendWord(6'h11);
    sendWord(6'h22);
    bus.run = 1'b1;
    waitIssue("t5_first", 6'h11, 6, dummy);
    @(negedge clk);
    bus.run = 1'b0;
    countIssues(6, seen);
    chk("t5_held",           32'(seen),            32'd0);
    chk("t5_count1",         32'(bus.fifo_count),  32'd1);
    bus.run = 1'b1;
    waitIssue("t5_second", 6'h22, 6, dummy);

    // Eight words with continuous draining: pointer wrap, order, no overflow
    fork
      begin
        for (int k = 0; k < 8; k++) sendWord(t6Words[k]);
      end
      begin
        for (int k = 0; k < 8; k++) waitIssue($sformatf("t6_w%0d", k), t6Words[k], 20, dummy);
      end
    join
    @(negedge clk);
    chk("t6_no_overflow",    32'(bus.overflow),    32'd0);
    chk("t6_empty",          32'(bus.empty),       32'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
